// File: rtl/e_input_cond.sv
// e_input_cond: synchronizes and debounces the async enable e, detects its
// qualified edges and captures a/b/c into a valid/ready holding register.
// Optional build macro: E_INPUT_COND_BOTH_EDGE_EN (falling edges also capture).
module e_input_cond #(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e_async,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             out_ready,
  output logic             e_clean,
  output logic             e_rise,
  output logic             out_valid,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {
    LOW_STABLE,
    CONFIRM_HIGH,
    HIGH_STABLE,
    CONFIRM_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   e_s;
  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   clean_nxt;
  logic                   handshake;
  logic                   cap_evt;

  assign e_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain on the raw enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], e_async};
  end

  // Filter state, counter and the clean level; edge pulses come from the
  // next-state level so e_rise lines up with the e_clean transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOW_STABLE;
      cnt     <= '0;
      e_clean <= 1'b0;
      e_rise  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      e_clean <= clean_nxt;
      e_rise  <= clean_nxt & ~e_clean;
    end
  end

  // Filter next-state: a level change must persist STABLE_CYCLES samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = e_clean;
    unique case (state)
      LOW_STABLE: begin
        if (e_s) begin
          state_nxt = CONFIRM_HIGH;
          cnt_nxt   = 4'd1;
        end
      end
      CONFIRM_HIGH: begin
        if (!e_s) begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'(STABLE_CYCLES)) begin
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
          clean_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH_STABLE: begin
        if (!e_s) begin
          state_nxt = CONFIRM_LOW;
          cnt_nxt   = 4'd1;
        end
      end
      CONFIRM_LOW: begin
        if (e_s) begin
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'(STABLE_CYCLES)) begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
          clean_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = LOW_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef E_INPUT_COND_BOTH_EDGE_EN
  logic e_fall;

  // Falling-edge pulse, used only to trigger captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_fall <= 1'b0;
    else        e_fall <= ~clean_nxt & e_clean;
  end

  assign cap_evt = e_rise | e_fall;
`else
  assign cap_evt = e_rise;
`endif

  assign handshake = out_valid & out_ready;

  // Holding register: capture on an edge event when empty or being drained,
  // otherwise count the lost capture (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      drop_cnt  <= '0;
    end else if (cap_evt) begin
      if (!out_valid || handshake) begin
        a_out     <= a_in;
        b_out     <= b_in;
        c_out     <= c_in;
        out_valid <= 1'b1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_e_input_cond.sv
// Directed bench for e_input_cond with a background protocol monitor.
module tb_e_input_cond;

  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_async = 1'b0;
  logic [11:0] a_in = '0;
  logic [11:0] b_in = '0;
  logic [11:0] c_in = '0;
  logic        out_ready = 1'b0;
  logic        e_clean, e_rise, out_valid;
  logic [11:0] a_out, b_out, c_out;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  e_input_cond #(.WIDTH(12), .SYNC_STAGES(2), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .e_async(e_async),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_ready(out_ready),
    .e_clean(e_clean), .e_rise(e_rise), .out_valid(out_valid),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Background monitor: no back-to-back e_rise, minimum e_clean dwell, no drop_cnt wrap.
  int         cyc = 0;
  int         last_tog = 0;
  int         rise_viol = 0;
  int         tog_viol = 0;
  int         wrap_viol = 0;
  logic       prev_rise = 1'b0;
  logic       prev_clean = 1'b0;
  logic [7:0] prev_drop = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_rise  <= 1'b0;
      prev_clean <= 1'b0;
      prev_drop  <= '0;
      last_tog   <= cyc;
    end else begin
      if (e_rise && prev_rise) rise_viol <= rise_viol + 1;
      if (e_clean !== prev_clean) begin
        if (cyc - last_tog < STABLE) tog_viol <= tog_viol + 1;
        last_tog <= cyc;
      end
      if (drop_cnt < prev_drop) wrap_viol <= wrap_viol + 1;
      prev_rise  <= e_rise;
      prev_clean <= e_clean;
      prev_drop  <= drop_cnt;
    end
  end

  task automatic pulse(input logic [11:0] v);
    a_in    = v;
    e_async = 1'b1;
    repeat (8) @(negedge clk);
    e_async = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int g_clean, g_rise, g_valid;
  logic found;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_clean", 32'(e_clean), 32'd0);
    check("rst_rise", 32'(e_rise), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_a", 32'(a_out), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Glitch: two periods high is too short to qualify
    g_clean = 0; g_rise = 0; g_valid = 0;
    e_async = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) e_async = 1'b0;
      @(negedge clk);
      if (e_clean) g_clean++;
      if (e_rise) g_rise++;
      if (out_valid) g_valid++;
    end
    check("glitch_clean", 32'(g_clean), 32'd0);
    check("glitch_rise", 32'(g_rise), 32'd0);
    check("glitch_valid", 32'(g_valid), 32'd0);

    // Clean capture: rise after 6th sampling edge, valid for one cycle
    a_in = 12'hDFC; b_in = 12'h5B4; c_in = 12'h0E7;
    out_ready = 1'b1;
    e_async = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("cap_rise@%0d", k), 32'(e_rise), 32'(k == 6));
      check($sformatf("cap_valid@%0d", k), 32'(out_valid), 32'(k == 7));
      if (k == 6) check("cap_clean", 32'(e_clean), 32'd1);
      if (k == 7) begin
        check("cap_a", 32'(a_out), 32'h0DFC);
        check("cap_b", 32'(b_out), 32'h05B4);
        check("cap_c", 32'(c_out), 32'h00E7);
      end
      if (k == 10) e_async = 1'b0;
    end
    repeat (10) @(negedge clk);
    check("cap_clean_low", 32'(e_clean), 32'd0);
    check("cap_valid_end", 32'(out_valid), 32'd0);

    // Backpressure: first rise captured, next two dropped
    out_ready = 1'b0;
    pulse(12'h001);
    pulse(12'h002);
    pulse(12'h003);
    check("bp_a", 32'(a_out), 32'h001);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_drop", 32'(drop_cnt), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_drain_a", 32'(a_out), 32'h001);
    out_ready = 1'b0;

    // Simultaneous accept + capture
    pulse(12'h001);
    check("sim_pre_a", 32'(a_out), 32'h001);
    check("sim_pre_valid", 32'(out_valid), 32'd1);
    a_in = 12'h0AA;
    e_async = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (e_rise) found = 1'b1;
    end
    check("sim_rise_seen", 32'(found), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("sim_a", 32'(a_out), 32'h0AA);
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_drop", 32'(drop_cnt), 32'd2);
    out_ready = 1'b0;
    e_async = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-stream with a pending capture
    check("mrst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_a", 32'(a_out), 32'd0);
    check("mrst_b", 32'(b_out), 32'd0);
    check("mrst_c", 32'(c_out), 32'd0);
    check("mrst_drop", 32'(drop_cnt), 32'd0);
    check("mrst_clean", 32'(e_clean), 32'd0);
    check("mrst_rise", 32'(e_rise), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_post_valid", 32'(out_valid), 32'd0);
    check("mrst_post_drop", 32'(drop_cnt), 32'd0);

    // Random stress on the raw enable
    out_ready = 1'b0;
    repeat (3334) begin
      #3 e_async = 1'($urandom_range(0, 1));
    end
    e_async = 1'b0;
    repeat (12) @(negedge clk);

    // Drive enough clean rises to saturate drop_cnt
    repeat (300) pulse(12'h055);
    check("sat_drop", 32'(drop_cnt), 32'hFF);
    check("sat_valid", 32'(out_valid), 32'd1);
    check("mon_wrap", 32'(wrap_viol), 32'd0);
    check("mon_rise_consec", 32'(rise_viol), 32'd0);
    check("mon_clean_dwell", 32'(tog_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
